// File: rtl/shift_reg_univ_if.sv
// shift_reg_univ_if: control, data and status bundle for the universal shift register.
// The master side (operand latches / sequencer) drives requests and data; the
// slave side (the register) returns its contents and burst status.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             load;
  logic [WIDTH-1:0] din;
  logic [2:0]       mode;
  logic             sin;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output load, din, mode, sin, start, cnt,
    input  dout, sout, busy, done
  );

  modport slave (
    input  load, din, mode, sin, start, cnt,
    output dout, sout, busy, done
  );
endinterface

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register with parallel load,
// shift/rotate, serial in/out and a counted-burst engine (IDLE/RUN/DONE).
// Optional feature: define SHIFT_ASR_EN to make mode 101 an arithmetic shift
// right; when undefined, 101 behaves as HOLD.
module shift_reg_univ #(
  parameter int WIDTH = 8
) (
  input logic            clock,
  input logic            reset_n,
  shift_reg_univ_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_ASR  = 3'b101
  } mode_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] dout_r, dout_n;
  logic             sout_r, sout_n;
  logic [2:0]       mode_r, mode_n;
  logic [CW-1:0]    rem, rem_n;

  logic [2:0]       op_mode;
  logic [WIDTH-1:0] sh_dout;
  logic             sh_sout;

  // One shift step of the current register contents; the burst uses the
  // latched mode, free-running operation uses the live mode input.
  assign op_mode = (state == S_RUN) ? mode_r : bus.mode;

  // Shift/rotate datapath: next register value and shifted-out bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned; a missing default would infer a latch.
    sh_dout = dout_r;
    sh_sout = sout_r;
    case (op_mode)
      M_SHL: begin
        sh_dout = {dout_r[WIDTH-2:0], bus.sin};
        sh_sout = dout_r[WIDTH-1];
      end
      M_SHR: begin
        sh_dout = {bus.sin, dout_r[WIDTH-1:1]};
        sh_sout = dout_r[0];
      end
      M_ROL: begin
        sh_dout = {dout_r[WIDTH-2:0], dout_r[WIDTH-1]};
        sh_sout = dout_r[WIDTH-1];
      end
      M_ROR: begin
        sh_dout = {dout_r[0], dout_r[WIDTH-1:1]};
        sh_sout = dout_r[0];
      end
`ifdef SHIFT_ASR_EN
      M_ASR: begin
        sh_dout = {dout_r[WIDTH-1], dout_r[WIDTH-1:1]};
        sh_sout = dout_r[0];
      end
`endif
      default: begin
        sh_dout = dout_r;
        sh_sout = sout_r;
      end
    endcase
  end

  // Next-state and register-update logic for the burst FSM.
  always_comb begin
    state_n = state;
    dout_n  = dout_r;
    sout_n  = sout_r;
    mode_n  = mode_r;
    rem_n   = rem;
    case (state)
      S_IDLE: begin
        if (bus.load) begin
          dout_n = bus.din;
        end else if (bus.start) begin
          if (bus.cnt != '0) begin
            mode_n  = bus.mode;
            rem_n   = bus.cnt;
            state_n = S_RUN;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          dout_n = sh_dout;
          sout_n = sh_sout;
        end
      end
      S_RUN: begin
        // A load aborts the burst; done is never raised for it.
        if (bus.load) begin
          dout_n  = bus.din;
          state_n = S_IDLE;
        end else begin
          dout_n = sh_dout;
          sout_n = sh_sout;
          rem_n  = rem - CW'(1);
          // rem is at least 1 in RUN, so this exit keeps it from underflowing.
          if (rem == CW'(1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.load) dout_n = bus.din;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state  <= S_IDLE;
      dout_r <= '0;
      sout_r <= 1'b0;
      mode_r <= 3'b000;
      rem    <= '0;
    end else begin
      state  <= state_n;
      dout_r <= dout_n;
      sout_r <= sout_n;
      mode_r <= mode_n;
      rem    <= rem_n;
    end
  end

  assign bus.dout = dout_r;
  assign bus.sout = sout_r;
  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
endmodule
